panda_lsu: RTL and testbench

PANDA_LSU -- requirements
Module: panda_lsu

---
 rtl/panda_pkg.sv | 33 +++
 rtl/panda_lsu_align.sv | 38 +++
 rtl/panda_lsu.sv | 144 ++++++++++++++
 tb/tb_panda_lsu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared types and helpers for the panda load/store unit.
// Sizes, FSM states and the split-access rule live here so the LSU and its aligner agree.
package panda_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StBeat0,
    StBeat1,
    StResp
  } lsu_state_e;

  localparam logic [1:0] SizeIllegal = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SizeByte: size_bytes = 3'd1;
      SizeHalf: size_bytes = 3'd2;
      default:  size_bytes = 3'd4;
    endcase
  endfunction

  // An access that runs past the end of its word needs a second RAM beat
  function automatic logic is_split(input logic [1:0] size, input logic [1:0] offset);
    is_split = ({1'b0, offset} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/panda_lsu_align.sv
// Combinational lane steering: store byte-enables and data shifting, load shift and extension.
// Works on a two-word window so split accesses are handled the same way as aligned ones.
module panda_lsu_align
  import panda_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] beat0_data,
  input  logic [31:0] beat1_data,
  output logic [7:0]  lane_mask,
  output logic [63:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  base_mask;
  logic [31:0] loaded;

  always_comb begin
    base_mask = 8'h0F;
    case (size)
      SizeByte: base_mask = 8'h01;
      SizeHalf: base_mask = 8'h03;
      default:  base_mask = 8'h0F;
    endcase
    lane_mask   = base_mask << offset;
    store_lanes = {32'h0, store_data} << {offset, 3'b000};

    loaded = 32'({beat1_data, beat0_data} >> {offset, 3'b000});
    case (size)
      SizeByte: load_data = {{24{~is_unsigned & loaded[7]}}, loaded[7:0]};
      SizeHalf: load_data = {{16{~is_unsigned & loaded[15]}}, loaded[15:0]};
      default:  load_data = loaded;
    endcase
  end

endmodule

// File: rtl/panda_lsu.sv
// Load/store unit bridging byte-addressed requests onto a 32-bit word RAM.
// Misaligned accesses crossing a word boundary are issued as two RAM beats.
module panda_lsu
  import panda_pkg::*;
#(
  parameter int AddrWidth    = 32,
  parameter int RamAddrWidth = 10,
  parameter int ReadLatency  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic [31:0]             req_wdata_i,
  output logic                    rsp_valid_o,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    ram_ce_o,
  output logic [3:0]              ram_we_o,
  output logic [RamAddrWidth-1:0] ram_addr_o,
  output logic [31:0]             ram_wdata_o,
  input  logic [31:0]             ram_rdata_i
);

  localparam logic [RamAddrWidth-1:0] WordStep = 1;

  lsu_state_e state_q, state_d;

  logic                    we_q;
  logic [1:0]              size_q;
  logic                    unsigned_q;
  logic [1:0]              offset_q;
  logic [RamAddrWidth-1:0] waddr_q;
  logic [31:0]             wdata_q;
  logic                    split_q;
  logic                    err_q;
  logic [31:0]             cap0_q;
  logic [31:0]             cap1_q;

  logic        accept;
  logic        req_err;
  logic [31:0] beat0_word;
  logic [31:0] beat1_word;
  logic [7:0]  lane_mask;
  logic [63:0] store_lanes;
  logic [31:0] load_data;

  assign accept  = req_valid_i && (state_q == StIdle);
  assign req_err = (req_size_i == SizeIllegal) || ((req_addr_i >> (RamAddrWidth + 2)) != '0);

  // With a registered RAM the final beat's data is still on ram_rdata_i during RESP
  assign beat0_word = ((ReadLatency != 0) && !split_q) ? ram_rdata_i : cap0_q;
  assign beat1_word = (ReadLatency != 0) ? ram_rdata_i : cap1_q;

  panda_lsu_align u_align (
    .size        (size_q),
    .offset      (offset_q),
    .is_unsigned (unsigned_q),
    .store_data  (wdata_q),
    .beat0_data  (beat0_word),
    .beat1_data  (beat1_word),
    .lane_mask   (lane_mask),
    .store_lanes (store_lanes),
    .load_data   (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      offset_q   <= 2'b00;
      waddr_q    <= '0;
      wdata_q    <= '0;
      split_q    <= 1'b0;
      err_q      <= 1'b0;
      cap0_q     <= '0;
      cap1_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= req_we_i;
        size_q     <= req_size_i;
        unsigned_q <= req_unsigned_i;
        offset_q   <= req_addr_i[1:0];
        waddr_q    <= req_addr_i[RamAddrWidth+1:2];
        wdata_q    <= req_wdata_i;
        split_q    <= is_split(req_size_i, req_addr_i[1:0]);
        err_q      <= req_err;
      end
      if (ReadLatency == 0) begin
        if (state_q == StBeat0) cap0_q <= ram_rdata_i;
        if (state_q == StBeat1) cap1_q <= ram_rdata_i;
      end else if (state_q == StBeat1) begin
        cap0_q <= ram_rdata_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    ram_ce_o    = 1'b0;
    ram_we_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = req_err ? StResp : StBeat0;
      end
      StBeat0: begin
        ram_ce_o    = 1'b1;
        ram_addr_o  = waddr_q;
        ram_we_o    = we_q ? lane_mask[3:0] : 4'h0;
        ram_wdata_o = store_lanes[31:0];
        state_d     = split_q ? StBeat1 : StResp;
      end
      StBeat1: begin
        ram_ce_o    = 1'b1;
        ram_addr_o  = waddr_q + WordStep;
        ram_we_o    = we_q ? lane_mask[7:4] : 4'h0;
        ram_wdata_o = store_lanes[63:32];
        state_d     = StResp;
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (!err_q && !we_q) ? load_data : 32'h0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_panda_lsu.sv
// Directed bench for panda_lsu: one instance per ReadLatency, each with its own RAM model,
// driven with identical requests and checked against hand-computed vectors.
module tb_panda_lsu;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [9:0]  exp_a0;
    logic [3:0]  exp_we0;
    logic [31:0] exp_wd0;
    logic [9:0]  exp_a1;
    logic [3:0]  exp_we1;
    logic [31:0] exp_wd1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        ready0, ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, ram_ce0, ram_ce1;
  logic [31:0] rsp_rdata0, rsp_rdata1, ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;
  logic [3:0]  ram_we0, ram_we1;
  logic [9:0]  ram_addr0, ram_addr1;

  logic [31:0] mem0 [1024] = '{default: 32'h0};
  logic [31:0] mem1 [1024] = '{default: 32'h0};
  logic [31:0] rdata1_q = '0;
  int          ce_total0 = 0, ce_total1 = 0, rsp_total0 = 0, rsp_total1 = 0;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs[19];

  always #5 clk = ~clk;

  panda_lsu #(.AddrWidth(32), .RamAddrWidth(10), .ReadLatency(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready0),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid0),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0), .ram_ce_o(ram_ce0),
    .ram_we_o(ram_we0), .ram_addr_o(ram_addr0), .ram_wdata_o(ram_wdata0),
    .ram_rdata_i(ram_rdata0)
  );

  panda_lsu #(.AddrWidth(32), .RamAddrWidth(10), .ReadLatency(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready1),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid1),
    .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err1), .ram_ce_o(ram_ce1),
    .ram_we_o(ram_we1), .ram_addr_o(ram_addr1), .ram_wdata_o(ram_wdata1),
    .ram_rdata_i(ram_rdata1)
  );

  // RAM models: combinational read for dut0, registered read for dut1
  assign ram_rdata0 = mem0[ram_addr0];
  assign ram_rdata1 = rdata1_q;

  always @(posedge clk) begin
    if (ram_ce0)
      for (int b = 0; b < 4; b++)
        if (ram_we0[b]) mem0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
    if (ram_ce1) begin
      rdata1_q <= mem1[ram_addr1];
      for (int b = 0; b < 4; b++)
        if (ram_we1[b]) mem1[ram_addr1][8*b +: 8] <= ram_wdata1[8*b +: 8];
    end
    ce_total0  <= ce_total0 + int'(ram_ce0);
    ce_total1  <= ce_total1 + int'(ram_ce1);
    rsp_total0 <= rsp_total0 + int'(rsp_valid0);
    rsp_total1 <= rsp_total1 + int'(rsp_valid1);
  end

  function automatic vec_t mkv(input string name, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic err, input int lat,
                               input logic [9:0] a0, input logic [3:0] we0, input logic [31:0] wd0,
                               input logic [9:0] a1, input logic [3:0] we1, input logic [31:0] wd1);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
    v.exp_a0 = a0; v.exp_we0 = we0; v.exp_wd0 = wd0;
    v.exp_a1 = a1; v.exp_we1 = we1; v.exp_wd1 = wd1;
    return v;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    checkOutput({v.name, "_ready"}, {30'b0, ready0, ready1}, 32'h3);
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_uns   = v.uns;
    req_addr  = v.addr;
    req_wdata = v.wdata;
  endtask

  task automatic runVector(input vec_t v);
    int          lat, ce0_before, ce1_before;
    logic [9:0]  oa0 [2], oa1 [2];
    logic [3:0]  owe0 [2], owe1 [2];
    logic [31:0] owd0 [2], owd1 [2];
    applyStimulus(v);
    ce0_before = ce_total0;
    ce1_before = ce_total1;
    @(negedge clk);
    req_valid = 1'b0;
    for (lat = 1; lat <= 6; lat++) begin
      if (lat <= 2) begin
        oa0[lat-1] = ram_addr0; owe0[lat-1] = ram_we0; owd0[lat-1] = ram_wdata0;
        oa1[lat-1] = ram_addr1; owe1[lat-1] = ram_we1; owd1[lat-1] = ram_wdata1;
      end
      if (rsp_valid0) break;
      @(negedge clk);
    end
    checkOutput({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    checkOutput({v.name, "_valid_rl1"}, {31'b0, rsp_valid1}, 32'h1);
    checkOutput({v.name, "_err_rl0"}, {31'b0, rsp_err0}, {31'b0, v.exp_err});
    checkOutput({v.name, "_err_rl1"}, {31'b0, rsp_err1}, {31'b0, v.exp_err});
    checkOutput({v.name, "_rdata_rl0"}, rsp_rdata0, v.exp_rdata);
    checkOutput({v.name, "_rdata_rl1"}, rsp_rdata1, v.exp_rdata);
    checkOutput({v.name, "_beats_rl0"}, 32'(ce_total0 - ce0_before), 32'(v.exp_lat - 1));
    checkOutput({v.name, "_beats_rl1"}, 32'(ce_total1 - ce1_before), 32'(v.exp_lat - 1));
    if (!v.exp_err) begin
      checkOutput({v.name, "_b0_addr"}, {6'b0, oa0[0], 6'b0, oa1[0]}, {6'b0, v.exp_a0, 6'b0, v.exp_a0});
      checkOutput({v.name, "_b0_we"}, {24'b0, owe0[0], owe1[0]}, {24'b0, v.exp_we0, v.exp_we0});
      if (v.exp_we0 != 4'h0) begin
        checkOutput({v.name, "_b0_wd_rl0"}, owd0[0] & lanes(v.exp_we0), v.exp_wd0 & lanes(v.exp_we0));
        checkOutput({v.name, "_b0_wd_rl1"}, owd1[0] & lanes(v.exp_we0), v.exp_wd0 & lanes(v.exp_we0));
      end
      if (v.exp_lat == 3) begin
        checkOutput({v.name, "_b1_addr"}, {6'b0, oa0[1], 6'b0, oa1[1]}, {6'b0, v.exp_a1, 6'b0, v.exp_a1});
        checkOutput({v.name, "_b1_we"}, {24'b0, owe0[1], owe1[1]}, {24'b0, v.exp_we1, v.exp_we1});
        if (v.exp_we1 != 4'h0) begin
          checkOutput({v.name, "_b1_wd_rl0"}, owd0[1] & lanes(v.exp_we1), v.exp_wd1 & lanes(v.exp_we1));
          checkOutput({v.name, "_b1_wd_rl1"}, owd1[1] & lanes(v.exp_we1), v.exp_wd1 & lanes(v.exp_we1));
        end
      end
    end
    @(negedge clk);
    checkOutput({v.name, "_pulse_end"}, {30'b0, rsp_valid0, rsp_valid1}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ce0_snap, ce1_snap, rsp0_snap, rsp1_snap;

    vecs[0]  = mkv("st_w8",    1, 2'b10, 0, 32'h8,    32'h11223344, 32'h0,        0, 2, 10'd2,    4'hF, 32'h11223344, 10'd0, 4'h0, 32'h0);
    vecs[1]  = mkv("ld_w8",    0, 2'b10, 0, 32'h8,    32'h0,        32'h11223344, 0, 2, 10'd2,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[2]  = mkv("st_b_b",   1, 2'b00, 0, 32'hB,    32'h80,       32'h0,        0, 2, 10'd2,    4'h8, 32'h80000000, 10'd0, 4'h0, 32'h0);
    vecs[3]  = mkv("ld_bs_b",  0, 2'b00, 0, 32'hB,    32'h0,        32'hFFFFFF80, 0, 2, 10'd2,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[4]  = mkv("ld_bu_b",  0, 2'b00, 1, 32'hB,    32'h0,        32'h00000080, 0, 2, 10'd2,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[5]  = mkv("st_w6",    1, 2'b10, 0, 32'h6,    32'hAABBCCDD, 32'h0,        0, 3, 10'd1,    4'hC, 32'hCCDD0000, 10'd2, 4'h3, 32'h0000AABB);
    vecs[6]  = mkv("ld_w6",    0, 2'b10, 0, 32'h6,    32'h0,        32'hAABBCCDD, 0, 3, 10'd1,    4'h0, 32'h0,        10'd2, 4'h0, 32'h0);
    vecs[7]  = mkv("ld_hs_a",  0, 2'b01, 0, 32'hA,    32'h0,        32'hFFFF8022, 0, 2, 10'd2,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[8]  = mkv("ld_hs_9",  0, 2'b01, 0, 32'h9,    32'h0,        32'h000022AA, 0, 2, 10'd2,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[9]  = mkv("st_h_fff", 1, 2'b01, 0, 32'hFFF,  32'hBEEF,     32'h0,        0, 3, 10'd1023, 4'h8, 32'hEF000000, 10'd0, 4'h1, 32'h000000BE);
    vecs[10] = mkv("ld_hu_fff",0, 2'b01, 1, 32'hFFF,  32'h0,        32'h0000BEEF, 0, 3, 10'd1023, 4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[11] = mkv("ld_bs_fff",0, 2'b00, 0, 32'hFFF,  32'h0,        32'hFFFFFFEF, 0, 2, 10'd1023, 4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[12] = mkv("ld_w0",    0, 2'b10, 0, 32'h0,    32'h0,        32'h000000BE, 0, 2, 10'd0,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[13] = mkv("err_size", 0, 2'b11, 0, 32'h8,    32'h0,        32'h0,        1, 1, 10'd0,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[14] = mkv("err_addr", 0, 2'b10, 0, 32'h1000, 32'h0,        32'h0,        1, 1, 10'd0,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[15] = mkv("err_st",   1, 2'b11, 0, 32'h4,    32'hDEADBEEF, 32'h0,        1, 1, 10'd0,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[16] = mkv("ld_hs_7",  0, 2'b01, 0, 32'h7,    32'h0,        32'hFFFFBBCC, 0, 3, 10'd1,    4'h0, 32'h0,        10'd2, 4'h0, 32'h0);
    vecs[17] = mkv("ld_bu_6",  0, 2'b00, 1, 32'h6,    32'h0,        32'h000000DD, 0, 2, 10'd1,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);
    vecs[18] = mkv("ld_w4",    0, 2'b10, 0, 32'h4,    32'h0,        32'hCCDD0000, 0, 2, 10'd1,    4'h0, 32'h0,        10'd0, 4'h0, 32'h0);

    #2 rst_n = 1'b0;
    #2;
    checkOutput("rst_rsp", {29'b0, rsp_valid0, rsp_err0, rsp_valid1 | rsp_err1}, 32'h0);
    checkOutput("rst_rdata", rsp_rdata0 | rsp_rdata1, 32'h0);
    checkOutput("rst_ram_ctl", {24'b0, ram_ce0, ram_ce1, 2'b0, ram_we0 | ram_we1}, 32'h0);
    checkOutput("rst_ram_addr", {12'b0, ram_addr0, ram_addr1}, 32'h0);
    checkOutput("rst_ram_wdata", ram_wdata0 | ram_wdata1, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", {30'b0, ready0, ready1}, 32'h3);

    for (int i = 0; i < 19; i++) runVector(vecs[i]);

    // Reset during BEAT0 of a split store must abandon it without any write or response
    ce0_snap  = ce_total0;
    ce1_snap  = ce_total1;
    rsp0_snap = rsp_total0;
    rsp1_snap = rsp_total1;
    applyStimulus(mkv("st_rst", 1, 2'b10, 0, 32'h15, 32'h12345678, 32'h0, 0, 3,
                      10'd5, 4'hE, 32'h0, 10'd6, 4'h1, 32'h0));
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst_mid_in_beat0", {30'b0, ram_ce0, ram_ce1}, 32'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ce", {30'b0, ram_ce0, ram_ce1}, 32'h0);
    checkOutput("rst_mid_we", {24'b0, ram_we0, ram_we1}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_ready", {30'b0, ready0, ready1}, 32'h3);
    checkOutput("rst_mid_no_beats", 32'((ce_total0 - ce0_snap) + (ce_total1 - ce1_snap)), 32'h0);
    checkOutput("rst_mid_no_rsp", 32'((rsp_total0 - rsp0_snap) + (rsp_total1 - rsp1_snap)), 32'h0);
    checkOutput("rst_mid_mem5", mem0[5] | mem1[5], 32'h0);
    checkOutput("rst_mid_mem6", mem0[6] | mem1[6], 32'h0);

    runVector(mkv("post_ld_w8",  0, 2'b10, 0, 32'h8,  32'h0, 32'h8022AABB, 0, 2,
                  10'd2, 4'h0, 32'h0, 10'd0, 4'h0, 32'h0));
    runVector(mkv("post_ld_w14", 0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 0, 2,
                  10'd5, 4'h0, 32'h0, 10'd0, 4'h0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
